text_ctrl: RTL

Text-mode sequencer for the 8x16 glyph font ROM. Maps the screen position to a character cell and reads the code from an internal single-port text buffer. Feeds the character to the font block with pipeline-aligned positions, then registers the returned glyph bit as the pixel, with cursor overlay. Arbitrates the text-buffer port between display reads, host single-character writes and a buffer-clear sequence.

---
 rtl/text_ctrl_if.sv | 17 +
 rtl/text_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/text_ctrl_if.sv
// Host write port of the text controller.
//   wr_req  : request, held by the host until wr_ack
//   wr_col  : target column
//   wr_row  : target row
//   wr_char : character code to store
//   wr_ack  : one-cycle accept pulse, same cycle the write is performed
// master = host side, slave = text_ctrl side.
interface text_ctrl_if;
  logic       wr_req;
  logic [6:0] wr_col;
  logic [4:0] wr_row;
  logic [7:0] wr_char;
  logic       wr_ack;

  modport master (output wr_req, wr_col, wr_row, wr_char, input wr_ack);
  modport slave  (input wr_req, wr_col, wr_row, wr_char, output wr_ack);
endinterface

// File: rtl/text_ctrl.sv
// Text-mode sequencer: maps the screen position to a character cell, reads
// the code from an internal single-port text buffer, hands it to the font
// block with 1-cycle-delayed positions, and registers the returned glyph bit
// as the pixel with a blinking cursor overlay. The buffer port is shared
// between display reads (active), the clear sequence and host writes.
// Ports:
//   px_clk, reset          : clock, synchronous active-high reset
//   pos_x/pos_y/active     : scan position and visible flag (C0)
//   frame_tick             : once per frame, drives the cursor blink
//   font_char/font_x/y     : to font block (C1)
//   font_data              : glyph bit back from font block (C2)
//   pixel/pixel_de         : registered output pixel and its valid (C3)
//   cursor_en/col/row      : cursor overlay control
//   host                   : host single-character write port
//   clear_req/busy         : fill buffer with CLEAR_CHAR, busy while filling
module text_ctrl #(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter int         ADDR_W       = 12,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] CLEAR_CHAR   = 8'h20
) (
  input  logic              px_clk,
  input  logic              reset,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              active,
  input  logic              frame_tick,
  output logic [7:0]        font_char,
  output logic [9:0]        font_x,
  output logic [9:0]        font_y,
  input  logic              font_data,
  output logic              pixel,
  output logic              pixel_de,
  input  logic              cursor_en,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  text_ctrl_if.slave        host,
  input  logic              clear_req,
  output logic              busy
);
  localparam int CELLS = COLS * ROWS;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;

  logic [7:0]        mem [CELLS];
  logic [ADDR_W-1:0] clr_ptr;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_we, clr_we, host_gnt;

  logic [1:0]        vld_pipe, grid_pipe, hit_pipe;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] c, input logic [4:0] r);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // C0: cell decode
  logic [6:0] col;
  logic [4:0] row;
  logic       in_grid, cur_hit, host_ok;
  assign col     = pos_x[9:3];
  assign row     = pos_y[8:4];
  assign in_grid = (int'(col) < COLS) && (int'(row) < ROWS);
  assign cur_hit = in_grid && (col == cursor_col) && (row == cursor_row);
  assign host_ok = (int'(host.wr_col) < COLS) && (int'(host.wr_row) < ROWS);

  // Port arbitration: display > clear > host. Host writes only from IDLE,
  // so they are never granted while busy.
  always_comb begin
    state_d  = state_q;
    clr_we   = 1'b0;
    host_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) state_d = CLEAR;
        if (!active && host.wr_req) host_gnt = 1'b1;
      end
      CLEAR: begin
        if (!active) begin
          clr_we = 1'b1;
          if (clr_ptr == LAST_CELL) state_d = IDLE;
        end
      end
    endcase
  end

  // Ack is combinational so the host sees it in the cycle the write happens.
  assign host.wr_ack = host_gnt & ~reset;
  assign busy        = (state_q == CLEAR);

  always_comb begin
    ram_addr = cell_addr(col, row);
    ram_din  = CLEAR_CHAR;
    ram_we   = 1'b0;
    if (clr_we) begin
      ram_addr = clr_ptr;
      ram_we   = 1'b1;
    end else if (host_gnt) begin
      ram_addr = cell_addr(host.wr_col, host.wr_row);
      ram_din  = host.wr_char;
      ram_we   = host_ok;            // out-of-range: acked, nothing stored
    end
    if (reset) ram_we = 1'b0;
  end

  always_ff @(posedge px_clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
  end

  // Registered read port doubles as font_char (C1); write-first.
  always_ff @(posedge px_clk) begin
    if (reset)                        font_char <= 8'h00;
    else if (ram_we)                  font_char <= ram_din;
    else if (int'(ram_addr) < CELLS)  font_char <= mem[ram_addr];
    else                              font_char <= 8'h00;
  end

  // C1..C3 pipeline alongside the buffer read and font lookup.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      font_x    <= '0;
      font_y    <= '0;
      vld_pipe  <= '0;
      grid_pipe <= '0;
      hit_pipe  <= '0;
      pixel     <= 1'b0;
      pixel_de  <= 1'b0;
    end else begin
      font_x    <= pos_x;
      font_y    <= pos_y;
      vld_pipe  <= {vld_pipe[0], active};
      grid_pipe <= {grid_pipe[0], in_grid};
      hit_pipe  <= {hit_pipe[0], cur_hit};
      pixel_de  <= vld_pipe[1];
      pixel     <= vld_pipe[1] & grid_pipe[1] &
                   (font_data ^ (hit_pipe[1] & blink_phase & cursor_en));
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_ptr     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) clr_ptr <= '0;
      else if (clr_we)     clr_ptr <= clr_ptr + ADDR_W'(1);
      if (frame_tick) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end
endmodule
